// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift sequencer: operation codes, controller states and
// the helper that tells which way an operation moves bits.
package shift_sequencer_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      SHL = 3'b000,
      SHR = 3'b001,
      SAR = 3'b010,
      ROL = 3'b011,
      ROR = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_e;

   function automatic logic is_left_op(input op_e op);
      return (op == SHL) || (op == ROL);
   endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/response handshake between an ALU controller (master) and the shift
// sequencer (slave).
interface shift_sequencer_if #(
   parameter int W  = 8,
   parameter int CW = $clog2(W) + 1
);
   import shift_sequencer_pkg::*;

   logic            start;
   logic [OP_W-1:0] op;
   logic [CW-1:0]   amount;
   logic [W-1:0]    operand;
   logic            busy;
   logic            done;
   logic            err;
   logic [W-1:0]    result;
   logic            carry_out;

   modport master (
      output start, op, amount, operand,
      input  busy, done, err, result, carry_out
   );

   modport slave (
      input  start, op, amount, operand,
      output busy, done, err, result, carry_out
   );

endinterface

// File: rtl/shift_seq_counter.sv
// Loadable down-counter holding the remaining shift count; loads clamp to W so
// oversized amounts behave like a full-width shift.
module shift_seq_counter #(
   parameter int W  = 8,
   parameter int CW = $clog2(W) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] load_val,
   output logic          is_one,
   output logic          is_zero
);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = (load_val > CW'(W)) ? CW'(W) : load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign is_one  = (count_q == CW'(1));
   assign is_zero = (count_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Control side of the ALU shift register: runs one shift/rotate command per start.
// Define SHIFT_SEQUENCER_ROTATE_EN to support ROL/ROR; otherwise they take the error path.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = $clog2(W) + 1
) (
   input  logic             clk,
   input  logic             rst,
   shift_sequencer_if.slave cmd,
   output logic [W-1:0]     sr_parallelIn,
   output logic             sr_load,
   output logic             sr_en,
   output logic             sr_lshift,
   output logic             sr_rshift,
   output logic             sr_serialIn,
   input  logic [W-1:0]     sr_parallelOut,
   input  logic             sr_serialOut
);

   state_e       state_q, state_d;
   op_e          op_q, op_d;
   logic [W-1:0] parallel_in_q, parallel_in_d;
   logic [W-1:0] result_q, result_d;
   logic [W-1:0] shifted;
   logic         busy_q, busy_d, done_q, done_d, err_q, err_d, carry_q, carry_d;
   logic         load_q, load_d, en_q, en_d, lshift_q, lshift_d, rshift_q, rshift_d;
   logic         serial_in, start_legal;
   logic         cnt_load, cnt_dec, cnt_one, cnt_zero;

   shift_seq_counter #(.W(W), .CW(CW)) u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cmd.amount),
      .is_one   (cnt_one),
      .is_zero  (cnt_zero)
   );

   always_comb begin
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      start_legal = cmd.op inside {SHL, SHR, SAR, ROL, ROR};
`else
      start_legal = cmd.op inside {SHL, SHR, SAR};
`endif
   end

   // Fill bit follows the live register contents, so it cannot be registered.
   always_comb begin
      serial_in = 1'b0;
      if (state_q == SHIFT) begin
         case (op_q)
            SAR:     serial_in = sr_parallelOut[W-1];
`ifdef SHIFT_SEQUENCER_ROTATE_EN
            ROL:     serial_in = sr_parallelOut[W-1];
            ROR:     serial_in = sr_parallelOut[0];
`endif
            default: serial_in = 1'b0;
         endcase
      end
   end

   // Value the register will hold after the final shift, so result is valid with done.
   assign shifted = lshift_q ? {sr_parallelOut[W-2:0], serial_in}
                             : {serial_in, sr_parallelOut[W-1:1]};

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      parallel_in_d = '0;
      result_d      = result_q;
      carry_d       = carry_q;
      err_d         = 1'b0;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd.start) begin
               cnt_load = 1'b1;
               if (start_legal) begin
                  state_d       = LOAD;
                  op_d          = op_e'(cmd.op);
                  parallel_in_d = cmd.operand;
               end else begin
                  state_d  = DONE;
                  err_d    = 1'b1;
                  result_d = '0;
                  carry_d  = 1'b0;
               end
            end
         end
         LOAD: begin
            if (cnt_zero) begin
               state_d  = DONE;
               result_d = parallel_in_q;
               carry_d  = 1'b0;
            end else begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            cnt_dec = 1'b1;
            if (cnt_one) begin
               state_d  = DONE;
               result_d = shifted;
               carry_d  = sr_serialOut;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      load_d   = (state_d == LOAD);
      en_d     = (state_d == LOAD) || (state_d == SHIFT);
      lshift_d = (state_d == SHIFT) && is_left_op(op_d);
      rshift_d = (state_d == SHIFT) && !is_left_op(op_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         op_q          <= SHL;
         parallel_in_q <= '0;
         result_q      <= '0;
         carry_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         load_q        <= 1'b0;
         en_q          <= 1'b0;
         lshift_q      <= 1'b0;
         rshift_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         parallel_in_q <= parallel_in_d;
         result_q      <= result_d;
         carry_q       <= carry_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         load_q        <= load_d;
         en_q          <= en_d;
         lshift_q      <= lshift_d;
         rshift_q      <= rshift_d;
      end
   end

   assign cmd.busy      = busy_q;
   assign cmd.done      = done_q;
   assign cmd.err       = err_q;
   assign cmd.result    = result_q;
   assign cmd.carry_out = carry_q;

   assign sr_parallelIn = parallel_in_q;
   assign sr_load       = load_q;
   assign sr_en         = en_q;
   assign sr_lshift     = lshift_q;
   assign sr_rshift     = rshift_q;
   assign sr_serialIn   = serial_in;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Sequencing controller for the `W`-bit shift register in the ALU datapath. It accepts one shift or rotate command with a start/busy/done handshake, then loads the operand into the register. It drives `load`, `en`, `lshift`, `rshift` and `serialIn` for the required number of cycles and returns the result plus the last bit shifted out. The shift register stays a separate instance; this block owns only the control side.

## Interface
- `W`, 8: register width; must match the controlled shift register.
- `CW`, `$clog2(W)+1`: width of the shift-amount field.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset; synchronous and active-low.
- `start` in 1: command strobe; sampled only in IDLE.
- `op` in 3: 000 SHL, 001 SHR (logical), 010 SAR (arithmetic right), 011 ROL, 100 ROR; other codes are illegal.
- `amount` in CW: shift count; values above `W` clamp to `W`.
- `operand` in W: value loaded into the register.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: pulses with `done` on an illegal op.
- `result` out W: registered final value, held until the next completion.
- `carry_out` out 1: last bit shifted out; 0 when the effective amount is 0.
- `sr_parallelIn` out W, `sr_load` out 1, `sr_en` out 1, `sr_lshift` out 1, `sr_rshift` out 1, `sr_serialIn` out 1: drive the shift register.
- `sr_parallelOut` in W, `sr_serialOut` in 1: read back from the shift register.

## Operation
- **States:**
  - IDLE: on `start`, latch `op` and the clamped `amount`, then go to LOAD. If `op` is illegal, go to DONE with `err` pending.
  - LOAD: `sr_load=1`, `sr_en=1`, `sr_parallelIn=operand` (captured at `start`). Next state is SHIFT, or DONE if the amount is 0.
  - SHIFT: `sr_en=1`, one shift per cycle, counter decrements. Leave for DONE on the cycle the counter reaches 1.
  - DONE: `done=1`, `result` and `carry_out` are updated, then go to IDLE.
- **Direction:** SHL/ROL assert `sr_lshift` only; SHR/SAR/ROR assert `sr_rshift` only. The two are never high together. `sr_load` is never high together with either shift.
- **`sr_serialIn`:**
  - SHL, SHR: 0.
  - SAR: `sr_parallelOut[W-1]`.
  - ROL: `sr_parallelOut[W-1]`.
  - ROR: `sr_parallelOut[0]`.
- **Carry:** `carry_out` is captured from `sr_serialOut` on every SHIFT cycle. The final capture is presented in DONE.
- **Illegal op:** no register activity (`sr_en=0` throughout). `result` becomes 0, `carry_out=0`, `err=1` together with `done`.
- **`start` while busy:** ignored; no queueing.
- **Outside LOAD/SHIFT:** every `sr_*` control output is 0.

## Timing
- Define edge E as the edge that samples `start` in IDLE. For effective amount n:
  - the register loads at E+1;
  - the last shift happens at E+1+n;
  - `done` is high during the cycle after E+1+n;
  - IDLE is re-entered at E+2+n.
- Illegal op: `done`/`err` are high during the cycle after E.
- Minimum spacing between accepted commands is n+3 edges.
- Reset (`rst=0` at an edge) from any state, including mid-SHIFT:
  - next state is IDLE;
  - `busy`, `done`, `err`, `carry_out` and all `sr_*` outputs go to 0;
  - `result` goes to 0.
- Reset does not clear the shift register contents; the system reset does that.

## Configuration
- `SHIFT_SEQUENCER_ROTATE_EN` defined: ROL and ROR are supported as described above.
- Not defined: ROL and ROR are treated as illegal ops (`err` path), and the rotate `serialIn` muxing is removed.

## Structure
- Package `shift_sequencer_pkg`:
  - `op_e` enum: SHL, SHR, SAR, ROL, ROR.
  - `state_e` enum: IDLE, LOAD, SHIFT, DONE.
  - `OP_W = 3` constant.
- One sub-module, `shift_seq_counter`: a loadable CW-bit down-counter with clamp-to-`W` on load and an `is_one`/`is_zero` flag.

## Test plan (W=8, macro defined unless stated)
- SHL, `operand=0x96`, `amount=3` → `result=0xB0`, `carry_out=0`, `done` in the cycle after E+4.
- SAR, `0x96`, `amount=2` → `result=0xE5`, `carry_out=1`; `sr_serialIn=1` on both shift cycles.
- ROR, `0x81`, `amount=1` → `result=0xC0`, `carry_out=1`. Same stimulus without the macro → `err=1`, `result=0x00`, `done` in the cycle after E, `sr_en` never high.
- SHR, `0x5A`, `amount=0` → `result=0x5A`, `carry_out=0`, `done` in the cycle after E+1. SHR, `0xFF`, `amount=12` → clamped to 8, `result=0x00`, `carry_out=1`, `done` in the cycle after E+9.
- `start` pulsed during SHIFT with a different op → ignored; the first command's result is unchanged.
- `rst=0` for one edge at the 2nd SHIFT cycle of SHL by 5 → IDLE next cycle, all outputs 0, no `done`; a new command afterwards completes normally.
